// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus responder slice:
// FSM encoding, bus word width and the data returned on a bus error.
package mio_pkg;
    localparam int MIO_WORD_W = 32;
    localparam logic [MIO_WORD_W-1:0] BUS_ERR_DATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } mio_state_e;
endpackage

// File: rtl/mio_sp_ram.sv
// Single-port synchronous word RAM, read-before-write, registered output.
// Contents are never reset.
module mio_sp_ram
    import mio_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [MIO_WORD_W-1:0] din,
    output logic [MIO_WORD_W-1:0] dout
);
    logic [MIO_WORD_W-1:0] mem_q [DEPTH];
    logic [MIO_WORD_W-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
        end
        dout_q <= mem_q[addr];
    end

    assign dout = dout_q;
endmodule

// File: rtl/mio_bus_responder.sv
// Slave end of the CPU_MIO / MIO_ready handshake: programmable wait
// states in front of a word-addressed data RAM.
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] addr_bus,
    input  logic [31:0] Data_out,
    output logic [31:0] Data_in,
    output logic        MIO_ready,
    output logic        bus_err,
    output logic        busy,
    output logic        proto_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    mio_state_e state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [MIO_WORD_W-1:0] wdata_q, wdata_d;
    logic                  inr_q, inr_d;
    logic [MIO_WORD_W-1:0] hold_q, hold_d;
    logic                  perr_q, perr_d;

    logic [31:0]           off;
    logic [29:0]           widx;
    logic                  req_inr;
    logic                  unused_bits;
    logic                  ram_we;
    logic [AW-1:0]         ram_addr;
    logic [MIO_WORD_W-1:0] ram_din;
    logic [MIO_WORD_W-1:0] ram_dout;

    // Below-base addresses are rejected before the subtraction can wrap.
    assign off         = addr_bus - ADDR_BASE;
    assign widx        = off[31:2];
    assign req_inr     = (addr_bus >= ADDR_BASE) && (32'(widx) < 32'(DEPTH));
    assign unused_bits = ^off[1:0];
    assign ram_addr    = (state_q == IDLE) ? widx[AW-1:0] : idx_q;

    mio_sp_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            inr_q   <= 1'b0;
            hold_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            inr_q   <= inr_d;
            hold_q  <= hold_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        inr_d   = inr_q;
        hold_d  = hold_q;
        perr_d  = perr_q;
        unique case (state_q)
            IDLE: begin
                if (CPU_MIO) begin
                    we_d    = mem_w;
                    idx_d   = widx[AW-1:0];
                    wdata_d = Data_out;
                    inr_d   = req_inr;
                    cnt_d   = WS;
                    state_d = (WS == 4'd0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!CPU_MIO) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    perr_d  = 1'b1;
                end else if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ACK;
                    cnt_d   = '0;
                end
            end
            ACK: begin
                state_d = IDLE;
                if (!inr_q) begin
                    hold_d = BUS_ERR_DATA;
                end else if (!we_q) begin
                    hold_d = ram_dout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The RAM is accessed on the edge that enters ACK, so its registered
    // output is the read data for the whole ACK cycle.
    always_comb begin
        MIO_ready = (state_q == ACK);
        bus_err   = (state_q == ACK) && !inr_q;
        busy      = (state_q != IDLE);
        proto_err = perr_q;
        Data_in   = hold_q;
        if (state_q == ACK) begin
            if (!inr_q) begin
                Data_in = BUS_ERR_DATA;
            end else if (!we_q) begin
                Data_in = ram_dout;
            end
        end
        ram_we  = 1'b0;
        ram_din = wdata_q;
        if (state_q == IDLE && state_d == ACK) begin
            ram_we  = mem_w && req_inr;
            ram_din = Data_out;
        end else if (state_q == WAIT && state_d == ACK) begin
            ram_we = we_q && inr_q;
        end
        ram_we = ram_we && rst_n;
    end
endmodule
